// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning (sync + debounce + press detect)
// and the IDLE/RUN/LAP/STOP mode FSM driving a 4-digit BCD counter.
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       cout3,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       ovf,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_LAP  = 2'b10;
  localparam logic [1:0] ST_STOP = 2'b11;

  // Counter value on the last cycle of a stable run; acceptance happens then.
  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_lap, btn_start};

  // Channel 0 = start/stop, channel 1 = lap/clear.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic       sync1_q;
      logic       sync2_q;
      logic       acc_q;
      logic       acc_d;
      logic       acc_dly_q;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;

      // Debounce: count consecutive cycles the synced level differs from the
      // accepted level; any cycle of agreement restarts the count.
      always_comb begin
        acc_d = acc_q;
        cnt_d = 8'd0;
        if (sync2_q != acc_q) begin
          if (cnt_q == DB_LAST) begin
            acc_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      // Synchronizer, debounce and edge-detect registers.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          acc_q     <= 1'b0;
          acc_dly_q <= 1'b0;
          cnt_q     <= 8'd0;
        end else begin
          sync1_q   <= btn_raw[gi];
          sync2_q   <= sync1_q;
          acc_q     <= acc_d;
          acc_dly_q <= acc_q;
          cnt_q     <= cnt_d;
        end
      end

      // Press = rising edge of the accepted level only.
      assign press[gi] = acc_q & ~acc_dly_q;
    end
  endgenerate

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       lap_hold_q;
  logic       lap_hold_d;
  logic       ovf_q;
  logic       ovf_d;
  logic       clr_q;
  logic       clr_d;
  logic       start_evt;
  logic       lap_evt;
  logic       ovf_evt;

  // Start wins over a coincident lap press.
  assign start_evt = press[0];
  assign lap_evt   = press[1] & ~press[0];
  assign ovf_evt   = cout3 & cnt_en;

  // FSM and status registers; clr resets high so the counter is cleared
  // through reset and the first cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lap_hold_q <= 1'b0;
      ovf_q      <= 1'b0;
      clr_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      lap_hold_q <= lap_hold_d;
      ovf_q      <= ovf_d;
      clr_q      <= clr_d;
    end
  end

  // Next-state logic; overflow takes priority over button presses.
  always_comb begin
    state_d    = state_q;
    lap_hold_d = lap_hold_q;
    ovf_d      = ovf_q;
    clr_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d    = ST_RUN;
          lap_hold_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (ovf_evt) begin
          state_d    = ST_STOP;
          ovf_d      = 1'b1;
          lap_hold_d = 1'b0;
        end else if (start_evt) begin
          state_d    = ST_STOP;
          lap_hold_d = 1'b0;
        end else if (lap_evt) begin
          state_d    = ST_LAP;
          lap_hold_d = 1'b1;
        end
      end
      ST_LAP: begin
        if (ovf_evt) begin
          state_d = ST_STOP;
          ovf_d   = 1'b1;
        end else if (start_evt) begin
          state_d = ST_STOP;
        end else if (lap_evt) begin
          state_d    = ST_RUN;
          lap_hold_d = 1'b0;
        end
      end
      default: begin
        if (start_evt) begin
          state_d    = ST_RUN;
          lap_hold_d = 1'b0;
        end else if (lap_evt) begin
          state_d    = ST_IDLE;
          lap_hold_d = 1'b0;
          ovf_d      = 1'b0;
          clr_d      = 1'b1;
        end
      end
    endcase
  end

  // Outputs; cnt_en is gated tick so it strobes once per tick while counting.
  always_comb begin
    cnt_en   = tick & ((state_q == ST_RUN) | (state_q == ST_LAP));
    cnt_clr  = clr_q;
    lap_hold = lap_hold_q;
    ovf      = ovf_q;
    state    = state_q;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: table of press/tick steps plus
// hand sequences for latency, bounce, clear pulse and async reset.
module tb_stopwatch_ctrl;

  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       cout3 = 1'b0;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_hold;
  logic       ovf;
  logic [1:0] state;

  int total = 0;
  int bad = 0;

  stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_start (btn_start),
    .btn_lap   (btn_lap),
    .cout3     (cout3),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .lap_hold  (lap_hold),
    .ovf       (ovf),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       l;
    logic       t;
    logic       c;
    logic [1:0] st;
    logic       lh;
    logic       ov;
    logic       en;
  } vec_t;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hold the buttons for 25 cycles, release, let release settle; count
  // cnt_clr-high cycles and state changes along the way.
  task automatic press_count(input logic s, input logic l, output int clr_n, output int chg_n);
    logic [1:0] prev;
    clr_n = 0;
    chg_n = 0;
    @(negedge clk);
    btn_start = s;
    btn_lap   = l;
    prev      = state;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cnt_clr) clr_n++;
      if (state != prev) chg_n++;
      prev = state;
      if (k == 24) begin
        btn_start = 1'b0;
        btn_lap   = 1'b0;
      end
    end
  endtask

  task automatic do_tick(input logic t, input logic c, output logic en_seen);
    @(negedge clk);
    tick  = t;
    cout3 = c;
    #1 en_seen = cnt_en;
    @(negedge clk);
    tick  = 1'b0;
    cout3 = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[23];

  initial begin
    int   clr_n;
    int   chg_n;
    logic en_seen;

    // step: s l t c | state lap_hold ovf cnt_en
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1};

    // Reset values, with tick high to show cnt_en is gated.
    #1 rst = 1'b0;
    tick = 1'b1;
    #2;
    chk("rst_state", 8'(state), 8'h0);
    chk("rst_cnt_en", 8'(cnt_en), 8'h0);
    chk("rst_lap_hold", 8'(lap_hold), 8'h0);
    chk("rst_ovf", 8'(ovf), 8'h0);
    chk("rst_cnt_clr", 8'(cnt_clr), 8'h1);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 chk("clr_after_release", 8'(cnt_clr), 8'h1);
    @(negedge clk);
    chk("clr_dropped", 8'(cnt_clr), 8'h0);
    $display("reset: state=%b cnt_clr=%b", state, cnt_clr);

    // Press latency: state must still be IDLE after 18 edges, RUN after 19.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("lat_18_idle", 8'(state), 8'h0);
    @(negedge clk);
    chk("lat_19_run", 8'(state), 8'h1);
    repeat (21) @(negedge clk);
    btn_start = 1'b0;
    repeat (25) @(negedge clk);
    chk("lat_still_run", 8'(state), 8'h1);
    $display("latency: state=%b", state);

    // Table-driven steps.
    for (int i = 0; i < 23; i++) begin
      en_seen = 1'b0;
      if (vecs[i].s | vecs[i].l) begin
        press_count(vecs[i].s, vecs[i].l, clr_n, chg_n);
      end else begin
        do_tick(vecs[i].t, vecs[i].c, en_seen);
        chk($sformatf("v%0d_cnt_en", i), 8'(en_seen), 8'(vecs[i].en));
      end
      chk($sformatf("v%0d_state", i), 8'(state), 8'(vecs[i].st));
      chk($sformatf("v%0d_lap_hold", i), 8'(lap_hold), 8'(vecs[i].lh));
      chk($sformatf("v%0d_ovf", i), 8'(ovf), 8'(vecs[i].ov));
      $display("vec %0d: s=%b l=%b t=%b c=%b -> state=%b lap_hold=%b ovf=%b cnt_en=%b",
               i, vecs[i].s, vecs[i].l, vecs[i].t, vecs[i].c, state, lap_hold, ovf, en_seen);
    end

    // Bouncing start button from STOP: exactly one change, to RUN.
    begin
      logic [1:0] prev;
      chg_n = 0;
      prev  = state;
      for (int k = 0; k < 90; k++) begin
        @(negedge clk);
        if (k < 60) btn_start = (((k / 5) % 2) == 0);
        else        btn_start = 1'b1;
        if (state != prev) chg_n++;
        prev = state;
      end
      btn_start = 1'b0;
      repeat (25) @(negedge clk);
      chk("bounce_changes", 8'(chg_n), 8'd1);
      chk("bounce_state", 8'(state), 8'h1);
      $display("bounce: changes=%0d state=%b", chg_n, state);
    end

    // Start then lap: STOP then IDLE with exactly one cnt_clr cycle.
    press_count(1'b1, 1'b0, clr_n, chg_n);
    chk("stop_state", 8'(state), 8'h3);
    chk("stop_no_clr", 8'(clr_n), 8'd0);
    press_count(1'b0, 1'b1, clr_n, chg_n);
    chk("clr_state", 8'(state), 8'h0);
    chk("clr_cycles", 8'(clr_n), 8'd1);
    chk("clr_ovf", 8'(ovf), 8'h0);
    $display("clear: state=%b cnt_clr_cycles=%0d ovf=%b", state, clr_n, ovf);

    // Async reset mid-LAP, between clock edges.
    press_count(1'b1, 1'b0, clr_n, chg_n);
    press_count(1'b0, 1'b1, clr_n, chg_n);
    chk("pre_rst_state", 8'(state), 8'h2);
    @(negedge clk);
    tick = 1'b1;
    #1 chk("pre_rst_en", 8'(cnt_en), 8'h1);
    #1 rst = 1'b0;
    #1;
    chk("async_state", 8'(state), 8'h0);
    chk("async_en", 8'(cnt_en), 8'h0);
    chk("async_lap_hold", 8'(lap_hold), 8'h0);
    chk("async_clr", 8'(cnt_clr), 8'h1);
    $display("async reset: state=%b cnt_en=%b lap_hold=%b cnt_clr=%b", state, cnt_en, lap_hold, cnt_clr);
    tick = 1'b0;

    // Button held through reset release: one press 18 edges later.
    @(negedge clk);
    btn_start = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("held_18_idle", 8'(state), 8'h0);
    @(negedge clk);
    chk("held_19_run", 8'(state), 8'h1);
    btn_start = 1'b0;
    repeat (25) @(negedge clk);
    chk("held_single", 8'(state), 8'h1);
    $display("held through reset: state=%b", state);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
